// File: rtl/conv_a1_ctrl.sv
// rtl/conv_a1_ctrl.sv - convolution layer controller: weight load, IFM stream and drain sequencing
// Optional macro CONV_A1_CTRL_PERF_EN adds the stall_count performance counter output.
module conv_a1_ctrl #(
    parameter int IFM_SIZE          = 32,
    parameter int IFM_DEPTH         = 3,
    parameter int KERNAL_SIZE       = 5,
    parameter int NUMBER_OF_FILTERS = 6,
    parameter int ADDRESS_BITS      = 15,
    parameter int CONV_LATENCY      = 4,
    localparam int FW = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1,
    localparam int DW = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    riscv_wm_write,
    input  logic [ADDRESS_BITS-1:0] riscv_wm_address,
    input  logic                    ifm_valid,
    output logic                    ifm_ready,
    output logic                    wm_enable_read,
    output logic                    wm_enable_write,
    output logic                    wm_fifo_enable,
    output logic                    fifo_enable,
    output logic                    conv_enable,
    output logic [ADDRESS_BITS-1:0] wm_address,
    output logic                    out_valid,
    output logic [FW-1:0]           filter_idx,
    output logic [DW-1:0]           depth_idx,
    output logic                    busy,
    output logic                    done
`ifdef CONV_A1_CTRL_PERF_EN
    ,
    output logic [31:0]             stall_count
`endif
);

    localparam int KK   = KERNAL_SIZE * KERNAL_SIZE;
    localparam int CMAX = (KK > CONV_LATENCY) ? KK : CONV_LATENCY;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RW   = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q;
    logic [RW-1:0]           row_q, col_q;
    logic [FW-1:0]           f_q;
    logic [DW-1:0]           d_q;
    logic [CONV_LATENCY-1:0] win_sr_q;
    logic                    rd_q;

    logic push, win_push, last_pix, load_last, drain_last, last_f, last_d;

    assign push       = (state_q == S_STREAM) && ifm_valid;
    assign win_push   = push && (row_q >= RW'(KERNAL_SIZE - 1)) && (col_q >= RW'(KERNAL_SIZE - 1));
    assign last_pix   = (row_q == RW'(IFM_SIZE - 1)) && (col_q == RW'(IFM_SIZE - 1));
    assign load_last  = (cnt_q == CW'(KK));
    assign drain_last = (cnt_q == CW'(CONV_LATENCY - 1));
    assign last_f     = (f_q == FW'(NUMBER_OF_FILTERS - 1));
    assign last_d     = (d_q == DW'(IFM_DEPTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ifm_ready       = 1'b0;
        wm_enable_read  = 1'b0;
        wm_enable_write = 1'b0;
        wm_address      = '0;
        conv_enable     = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                // Host owns the weight memory only while idle; reset forces the bus quiet.
                if (reset) begin
                    wm_address      = riscv_wm_address;
                    wm_enable_write = riscv_wm_write;
                end
                if (start) begin
                    state_d = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (cnt_q < CW'(KK)) begin
                    wm_enable_read = 1'b1;
                    wm_address     = ADDRESS_BITS'(f_q) * ADDRESS_BITS'(KK) + ADDRESS_BITS'(cnt_q);
                end
                if (load_last) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                ifm_ready   = 1'b1;
                conv_enable = 1'b1;
                if (push && last_pix) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                conv_enable = 1'b1;
                if (drain_last) begin
                    state_d = (last_f && last_d) ? S_DONE : S_LOAD_W;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            f_q      <= '0;
            d_q      <= '0;
            win_sr_q <= '0;
            rd_q     <= 1'b0;
        end else begin
            // Weight memory has one cycle of read latency, so the FIFO push trails the read.
            rd_q     <= wm_enable_read;
            win_sr_q <= (win_sr_q << 1) | CONV_LATENCY'(win_push);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
                        row_q <= '0;
                        col_q <= '0;
                        f_q   <= '0;
                        d_q   <= '0;
                    end
                end
                S_LOAD_W: begin
                    cnt_q <= load_last ? '0 : cnt_q + 1'b1;
                    row_q <= '0;
                    col_q <= '0;
                end
                S_STREAM: begin
                    cnt_q <= '0;
                    if (push) begin
                        if (last_pix) begin
                            row_q <= '0;
                            col_q <= '0;
                        end else if (col_q == RW'(IFM_SIZE - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_last) begin
                        cnt_q <= '0;
                        if (last_d) begin
                            d_q <= '0;
                            if (!last_f) begin
                                f_q <= f_q + 1'b1;
                            end
                        end else begin
                            d_q <= d_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign wm_fifo_enable = rd_q;
    assign fifo_enable    = push;
    assign out_valid      = win_sr_q[CONV_LATENCY-1];
    assign filter_idx     = f_q;
    assign depth_idx      = d_q;

`ifdef CONV_A1_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            stall_count <= '0;
        end else if ((state_q == S_STREAM) && !ifm_valid && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_a1_ctrl.sv
// tb/tb_conv_a1_ctrl.sv - self-checking bench for conv_a1_ctrl
module tb_conv_a1_ctrl;

    localparam int S     = 32;
    localparam int DEPTH = 3;
    localparam int K     = 5;
    localparam int NF    = 6;
    localparam int AB    = 15;
    localparam int L     = 4;
    localparam int KK    = K * K;
    localparam int NSEG  = NF * DEPTH;
    localparam int WIN   = (S - K + 1) * (S - K + 1);
    localparam int LIMIT = 40000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          riscv_wm_write;
    logic [AB-1:0] riscv_wm_address;
    logic          ifm_valid;
    logic          ifm_ready, wm_enable_read, wm_enable_write, wm_fifo_enable;
    logic          fifo_enable, conv_enable, out_valid, busy, done;
    logic [AB-1:0] wm_address;
    logic [2:0]    filter_idx;
    logic [1:0]    depth_idx;
`ifdef CONV_A1_CTRL_PERF_EN
    logic [31:0]   stall_count;
`endif

    always #5 clk = ~clk;

    conv_a1_ctrl #(
        .IFM_SIZE(S), .IFM_DEPTH(DEPTH), .KERNAL_SIZE(K),
        .NUMBER_OF_FILTERS(NF), .ADDRESS_BITS(AB), .CONV_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .riscv_wm_write(riscv_wm_write), .riscv_wm_address(riscv_wm_address),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
        .wm_enable_read(wm_enable_read), .wm_enable_write(wm_enable_write),
        .wm_fifo_enable(wm_fifo_enable), .fifo_enable(fifo_enable),
        .conv_enable(conv_enable), .wm_address(wm_address), .out_valid(out_valid),
        .filter_idx(filter_idx), .depth_idx(depth_idx), .busy(busy), .done(done)
`ifdef CONV_A1_CTRL_PERF_EN
        , .stall_count(stall_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        logic [63:0] v;
        v = {35'd0, ifm_ready, wm_enable_read, wm_enable_write, wm_fifo_enable, fifo_enable,
             conv_enable, wm_address, out_valid, filter_idx, depth_idx, busy, done};
`ifdef CONV_A1_CTRL_PERF_EN
        v = v | {stall_count, 32'd0};
`endif
        return v;
    endfunction

    // Reference model state: event counts per (filter, depth) segment and expected out_valid times.
    int  cyc, seg_n, rd_k, pix, ov, seg_err, conv_cnt, ready_cnt, done_cnt, busy_err;
    bit  seg_open, prev_rd, prev_done, last_ready;
    int  exp_q[$];
    longint stall_m;

    task automatic mon_reset();
        cyc = 0; seg_n = -1; rd_k = 0; pix = 0; ov = 0; seg_err = 0;
        conv_cnt = 0; ready_cnt = 0; done_cnt = 0; busy_err = 0;
        seg_open = 0; prev_rd = 0; prev_done = 0; last_ready = 0;
        stall_m = 0;
        exp_q.delete();
    endtask

    task automatic finalize();
        if (seg_open) begin
            chk($sformatf("seg%0d_reads", seg_n), rd_k, KK);
            chk($sformatf("seg%0d_pushes", seg_n), pix, S * S);
            chk($sformatf("seg%0d_out_valid", seg_n), ov, WIN);
            chk($sformatf("seg%0d_conv_enable", seg_n), conv_cnt, ready_cnt + L);
            chk($sformatf("seg%0d_pending", seg_n), exp_q.size(), 0);
            chk($sformatf("seg%0d_protocol", seg_n), seg_err, 0);
            seg_err  = 0;
            seg_open = 0;
        end
    endtask

    task automatic mon_step();
        bit push, exp_ov;
        cyc++;
        if (wm_enable_read && !prev_rd) begin
            finalize();
            seg_n++;
            seg_open = 1;
            rd_k = 0; pix = 0; ov = 0; conv_cnt = 0; ready_cnt = 0;
            chk($sformatf("seg%0d_filter_idx", seg_n), filter_idx, seg_n / DEPTH);
            chk($sformatf("seg%0d_depth_idx", seg_n), depth_idx, seg_n % DEPTH);
            chk($sformatf("seg%0d_first_addr", seg_n), wm_address, (seg_n / DEPTH) * KK);
        end
        if (wm_enable_read) begin
            if (int'(wm_address) != (seg_n / DEPTH) * KK + rd_k) seg_err++;
            rd_k++;
        end
        if (wm_fifo_enable !== prev_rd) seg_err++;
        push = ifm_valid && ifm_ready;
        if (fifo_enable !== push) seg_err++;
        if (push) begin
            if ((pix / S) >= K - 1 && (pix % S) >= K - 1) exp_q.push_back(cyc + L);
            pix++;
        end
        exp_ov = (exp_q.size() > 0) && (exp_q[0] == cyc);
        if (exp_ov) void'(exp_q.pop_front());
        if (out_valid !== exp_ov) seg_err++;
        if (out_valid) ov++;
        if (conv_enable) conv_cnt++;
        if (ifm_ready) ready_cnt++;
        if (ifm_ready && !ifm_valid) stall_m++;
        if (busy && wm_enable_write) busy_err++;
        if (prev_done && busy) busy_err++;
        if (done) begin
            done_cnt++;
            if (!busy) busy_err++;
            finalize();
        end
        prev_rd    = wm_enable_read;
        prev_done  = done;
        last_ready = ifm_ready;
    endtask

    task automatic tick();
        @(negedge clk);
        mon_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input bit rnd, input int stop_seg, input int stop_pix);
        int n;
        mon_reset();
        start = 1'b1; riscv_wm_write = 1'b1; riscv_wm_address = 15'd7;
        #1;
        chk("start_cycle_host_we", wm_enable_write, 1);
        chk("start_cycle_host_addr", wm_address, 7);
        tick();
        start = 1'b0; riscv_wm_write = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < LIMIT) begin
            if (stop_seg >= 0 && seg_n == stop_seg && pix == stop_pix) break;
            ifm_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd) begin
                start            = last_ready && ($urandom_range(0, 63) == 0);
                riscv_wm_write   = $urandom_range(0, 1) != 0;
                riscv_wm_address = AB'($urandom);
            end
            tick();
            n++;
        end
        start = 1'b0; riscv_wm_write = 1'b0; ifm_valid = 1'b0;
        if (stop_seg >= 0) begin
            chk("stop_point_reached", seg_n * 100000 + pix, stop_seg * 100000 + stop_pix);
        end else begin
            tick();
            chk("pass_segments", seg_n + 1, NSEG);
            chk("done_pulses", done_cnt, 1);
            chk("busy_protocol", busy_err, 0);
            chk("busy_low_after_done", busy, 0);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AB-1:0] addr;
        logic          exp_we;
        logic [AB-1:0] exp_addr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{1'b1, 15'd7,     1'b1, 15'd7};
        tbl[1] = '{1'b0, 15'd9,     1'b0, 15'd9};
        tbl[2] = '{1'b1, 15'h7fff,  1'b1, 15'h7fff};
        tbl[3] = '{1'b1, 15'd0,     1'b1, 15'd0};
        tbl[4] = '{1'b0, 15'h2aaa,  1'b0, 15'h2aaa};

        reset = 1'b0; start = 1'b0; ifm_valid = 1'b1;
        riscv_wm_write = 1'b1; riscv_wm_address = 15'd7;
        mon_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", outs_vec(), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        riscv_wm_write = 1'b0; ifm_valid = 1'b0;
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            riscv_wm_write   = tbl[i].wr;
            riscv_wm_address = tbl[i].addr;
            #1;
            chk($sformatf("idle_vec%0d_we", i), wm_enable_write, tbl[i].exp_we);
            chk($sformatf("idle_vec%0d_addr", i), wm_address, tbl[i].exp_addr);
            tick();
        end
        riscv_wm_write = 1'b0;

        // Full layer pass with a continuous pixel stream.
        run_pass(1'b0, -1, 0);
`ifdef CONV_A1_CTRL_PERF_EN
        chk("stall_count_no_stalls", stall_count, stall_m);
`endif

        // Randomly stalled stream with host writes and stray start pulses while busy.
        run_pass(1'b1, -1, 0);
`ifdef CONV_A1_CTRL_PERF_EN
        chk("stall_count_random", stall_count, stall_m);
`endif

        // Asynchronous reset mid-stream, then a fresh pass must start from filter 0.
        run_pass(1'b0, 7, 500);
        chk("busy_before_reset", busy, 1);
        riscv_wm_write = 1'b1; riscv_wm_address = 15'd7; ifm_valid = 1'b1;
        #1;
        chk("busy_host_write_dropped", wm_enable_write, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs_zero", outs_vec(), 64'd0);
        @(posedge clk);
        #1;
        chk("held_reset_outputs_zero", outs_vec(), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        riscv_wm_write = 1'b0; ifm_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_idle", busy, 0);
        run_pass(1'b0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
